relatorio_serial_tx: RTL
========================

// Module: relatorio_serial_tx
// PURPOSE
//  Serial transmitter, the return path of the weighing-gate link. On request it sends a
//  report (max/min/current weight digits, same 6-nibble layout the receiver fills) over
//  one UART line as ASCII characters, optionally followed by a terminator character.
//  Sits beside circuito_fd; circuito_uc pulses partida after a frame is accepted.
// PARAMETERS
//  NUM_DIG        6      number of 4-bit digits per report
//  DIV            434    clock cycles per serial bit (50 MHz / 115200 baud)
//  USA_TERMINADOR 1      1: append TERMINADOR after the digits; 0: digits only
//  TERMINADOR     7'h0A  7-bit ASCII terminator character
// PORTS
//  clock         in   1           system clock, rising edge
//  reset         in   1           synchronous, active-high
//  partida       in   1           start request, sampled only in INICIAL
//  digitos       in   4*NUM_DIG   digits; [4*NUM_DIG-1 -: 4] sent first
//  saida_serial  out  1           serial line, idle high
//  ocupado       out  1           high from PREPARA through FINAL
//  pronto        out  1           one-cycle pulse when the report is complete
//  db_estado     out  4           state code for hexa7seg display
// BEHAVIOUR
//  - One clock domain. Reset is synchronous and active-high. Reset gives state INICIAL,
//    saida_serial=1, ocupado=0, pronto=0, and all counters at 0.
//  - Character format is 7E2: start 0, 7 data bits LSB first, even parity, 2 stops at 1.
//    Each character is 11 bits. Each bit lasts exactly DIV cycles.
//  - ASCII map: d<=9 -> 7'h30+d; d in A..F -> 7'h41+(d-10).
//  - States and codes:
//    - INICIAL=0: line 1. If partida=1, latch digitos, clear the character index, go to PREPARA.
//    - PREPARA=1: line 1 for one cycle. Load the 11-bit shift register with the current char.
//      Clear the bit and tick counters. Go to TRANSMITE.
//    - TRANSMITE=2: line = shift[0]. Every DIV cycles shift right and increment the bit count.
//      After bit 11 ends: if more chars remain, index++ and go to PREPARA; else go to FINAL.
//    - FINAL=4: pronto=1 and line 1 for one cycle, then go to INICIAL.
//  - Timing: partida is sampled at edge 0, so PREPARA is cycle 1 and the start bit begins
//    at cycle 2. N = NUM_DIG+USA_TERMINADOR characters. pronto is high during cycle
//    1+N*(11*DIV+1). Characters are separated by exactly one idle-high cycle.
//  - partida while ocupado=1 is ignored, with no queueing. partida held high after FINAL
//    starts a new report on the next INICIAL cycle.
//  - digitos changes during a transfer have no effect; the latched copy is sent.
//  - Reset mid-character: the line returns high on the next cycle and the partial char is
//    dropped, with no pronto.
//  - DIV counter width is $clog2(DIV). The bit counter is 4 bits. The index counter is
//    $clog2(NUM_DIG+2) bits.
// STRUCTURE
//  - Shared package or include: state codes (INICIAL/PREPARA/TRANSMITE/FINAL), the 7E2
//    frame constants (11 bits, parity even), and the function hex_para_ascii(4b)->7b.
//    The receiver side reuses the same package.
//  - Sub-module: contador_m (modulo DIV, zera/conta, fim output) as the baud tick. FSM and
//    shift register stay in this file.
// TESTING (DIV=4 in simulation)
//  - digitos=24'h123456, USA_TERMINADOR=1, partida pulse: decoded chars are
//    31,32,33,34,35,36,0A. pronto is at cycle 1+7*45=316.
//  - Single char 'A' (nibble A): line = 0,1,0,0,0,0,0,1,0,1,1, each level for 4 cycles.
//    Parity bit is 0 because 7'h41 has two ones.
//  - Char '7' (7'h37, five ones): parity bit is 1. The bench parity checker passes on all chars.
//  - partida pulsed again mid-report, and digitos changed at cycle 50: output is identical
//    to the undisturbed run, with one pronto only.
//  - reset asserted at cycle 100: saida_serial=1 at cycle 101, state 0, no pronto.
//    A new partida then sends a full clean report.
//  - USA_TERMINADOR=0, NUM_DIG=1: exactly one char is sent. pronto is at cycle 46 and
//    ocupado falls on the cycle after.

Source files
------------

// File: rtl/relatorio_serial_tx_pkg.sv
// Shared definitions for the weighing-gate serial link (transmitter and receiver).
//  - estado_t      : FSM state codes, also shown on the hexa7seg display
//  - BITS_QUADRO   : bits per 7E2 character (start + 7 data + parity + 2 stops)
//  - hex_para_ascii: 4-bit digit -> 7-bit ASCII ('0'..'9', 'A'..'F')
//  - monta_quadro  : 7-bit ASCII -> 11-bit frame, bit 0 goes on the line first
package relatorio_serial_tx_pkg;

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        PREPARA   = 4'd1,
        TRANSMITE = 4'd2,
        FINAL     = 4'd4
    } estado_t;

    localparam int   BITS_DADO    = 7;
    localparam int   BITS_QUADRO  = 11;
    localparam logic PARIDADE_PAR = 1'b1;

    function automatic logic [6:0] hex_para_ascii(input logic [3:0] d);
        if (d <= 4'd9)
            return 7'h30 + 7'(d);
        else
            return 7'h37 + 7'(d);   // 7'h41 + (d - 10)
    endfunction

    // {stop, stop, parity, data[6:0], start}; shifted out LSB first.
    function automatic logic [10:0] monta_quadro(input logic [6:0] c);
        return {2'b11, (^c) ^ ~PARIDADE_PAR, c, 1'b0};
    endfunction

endpackage

// File: rtl/relatorio_serial_tx_contador.sv
// contador_m: modulo-M counter used as the baud tick.
//  clock in  system clock
//  reset in  synchronous active-high reset
//  zera  in  synchronous clear (priority over conta)
//  conta in  count enable; wraps from M-1 to 0
//  fim   out high while the count equals M-1 (last cycle of a bit)
module contador_m #(
    parameter  int M = 434,
    localparam int W = (M > 1) ? $clog2(M) : 1
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clock) begin
        if (reset || zera)
            q_reg <= '0;
        else if (conta)
            q_reg <= (q_reg == W'(M - 1)) ? '0 : q_reg + 1'b1;
    end

    assign fim = (q_reg == W'(M - 1));

endmodule

// File: rtl/relatorio_serial_tx.sv
// relatorio_serial_tx: sends a weight report as 7E2 ASCII characters on one UART line.
//  clock        in  system clock
//  reset        in  synchronous active-high reset
//  partida      in  start request, only looked at while idle
//  digitos      in  4*NUM_DIG digit nibbles, most significant nibble sent first
//  saida_serial out serial line, idle high
//  ocupado      out high while a report is in progress
//  pronto       out one-cycle pulse after the last character
//  db_estado    out current state code
module relatorio_serial_tx
    import relatorio_serial_tx_pkg::*;
#(
    parameter int         NUM_DIG        = 6,
    parameter int         DIV            = 434,
    parameter int         USA_TERMINADOR = 1,
    parameter logic [6:0] TERMINADOR     = 7'h0A
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   partida,
    input  logic [4*NUM_DIG-1:0]   digitos,
    output logic                   saida_serial,
    output logic                   ocupado,
    output logic                   pronto,
    output logic [3:0]             db_estado
);

    localparam int N_CHARS = NUM_DIG + USA_TERMINADOR;
    localparam int W_IDX   = $clog2(NUM_DIG + 2);
    localparam int N_TAB   = 1 << W_IDX;

    estado_t                estado_reg, estado_next;
    logic [4*NUM_DIG-1:0]   digitos_reg;
    logic [W_IDX-1:0]       idx_reg;
    logic [3:0]             bit_cnt_reg;
    logic [10:0]            shift_reg;
    logic                   tick_fim;
    logic                   ultimo_bit;
    logic                   ultimo_char;
    logic [6:0]             tabela [0:N_TAB-1];

    // Character table from the latched digits; every index past the digits maps
    // to the terminator, so idx_reg can address the table without a bound check.
    genvar gi;
    generate
        for (gi = 0; gi < N_TAB; gi++) begin : g_tabela
            if (gi < NUM_DIG) begin : g_dig
                assign tabela[gi] = hex_para_ascii(digitos_reg[4*(NUM_DIG-1-gi) +: 4]);
            end else begin : g_term
                assign tabela[gi] = TERMINADOR;
            end
        end
    endgenerate

    contador_m #(.M(DIV)) u_baud (
        .clock (clock),
        .reset (reset),
        .zera  (estado_reg == PREPARA),
        .conta (estado_reg == TRANSMITE),
        .fim   (tick_fim)
    );

    assign ultimo_bit  = tick_fim && (bit_cnt_reg == 4'(BITS_QUADRO - 1));
    assign ultimo_char = (idx_reg == W_IDX'(N_CHARS - 1));

    // State register
    always_ff @(posedge clock) begin
        if (reset)
            estado_reg <= INICIAL;
        else
            estado_reg <= estado_next;
    end

    // Next state and outputs
    always_comb begin
        estado_next  = estado_reg;
        saida_serial = 1'b1;
        ocupado      = 1'b1;
        pronto       = 1'b0;
        case (estado_reg)
            INICIAL: begin
                ocupado = 1'b0;
                if (partida)
                    estado_next = PREPARA;
            end
            PREPARA: begin
                estado_next = TRANSMITE;
            end
            TRANSMITE: begin
                saida_serial = shift_reg[0];
                if (ultimo_bit)
                    estado_next = ultimo_char ? FINAL : PREPARA;
            end
            FINAL: begin
                pronto      = 1'b1;
                estado_next = INICIAL;
            end
            default: begin
                ocupado     = 1'b0;
                estado_next = INICIAL;
            end
        endcase
    end

    assign db_estado = estado_reg;

    // Datapath: digit latch, character index, frame shift register, bit count
    always_ff @(posedge clock) begin
        if (reset) begin
            digitos_reg <= '0;
            idx_reg     <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '1;
        end else begin
            case (estado_reg)
                INICIAL: begin
                    if (partida) begin
                        digitos_reg <= digitos;
                        idx_reg     <= '0;
                    end
                end
                PREPARA: begin
                    shift_reg   <= monta_quadro(tabela[idx_reg]);
                    bit_cnt_reg <= '0;
                end
                TRANSMITE: begin
                    if (tick_fim) begin
                        shift_reg   <= {1'b1, shift_reg[10:1]};
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        if (ultimo_bit && !ultimo_char)
                            idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
